md_sequencer: RTL and testbench

Multiply/divide sequencer for the execute stage: accepts a one-cycle start command with two 32-bit operands, models the fixed multi-cycle latency of MIPS `mult`/`multu`/`div`/`divu`, and commits results to the architectural HI/LO registers. It also handles `mthi`/`mtlo` writes and produces the stall request the hazard unit uses to hold `mfhi`/`mflo`/md instructions in decode while the unit is occupied. It sits beside the ALU in E and is driven by the main decoder's MDOP field.

---
 rtl/md_pkg.sv | 21 ++
 rtl/md_arith.sv | 61 ++++++
 rtl/md_sequencer.sv | 132 +++++++++++++
 tb/tb_md_sequencer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer: MDOP codes, FSM states
// and default latencies.
package md_pkg;

  localparam int MD_WIDTH       = 32;
  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: {hi, lo} result for the MDOP given,
// plus a divide-by-zero flag. Holds no state.
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [2:0]         mdop,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  logic               is_div;
  logic               is_signed_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   num;
  logic [WIDTH-1:0]   den;
  logic [WIDTH-1:0]   quo_mag;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;

  // Signed product via sign extension; the low 2*WIDTH bits are exact.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign is_div        = (mdop == MD_DIV) || (mdop == MD_DIVU);
  assign is_signed_div = (mdop == MD_DIV);
  assign div_by_zero   = is_div && (b == '0);

  // Signed divide runs on magnitudes so truncation is toward zero and the
  // remainder takes the dividend's sign; the zero-divisor guard keeps it defined.
  assign a_neg   = is_signed_div && a[WIDTH-1];
  assign b_neg   = is_signed_div && b[WIDTH-1];
  assign a_mag   = a_neg ? (~a + 1'b1) : a;
  assign b_mag   = b_neg ? (~b + 1'b1) : b;
  assign num     = a_mag;
  assign den     = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign quo_mag = num / den;
  assign rem_mag = num % den;
  assign quo     = (a_neg ^ b_neg) ? (~quo_mag + 1'b1) : quo_mag;
  assign rem     = a_neg ? (~rem_mag + 1'b1) : rem_mag;

  always_comb begin
    result = '0;
    case (mdop)
      MD_MULT:          result = prod_s;
      MD_MULTU:         result = prod_u;
      MD_DIV, MD_DIVU:  result = {rem, quo};
      default:          result = '0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: fixed-latency busy period, pending result
// committed to HI/LO at the end, mthi/mtlo writes and the decode stall request.
module md_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH       = MD_WIDTH,
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [2:0]       MDOP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MDUse,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mask_q, mask_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   phi_q, phi_d;
  logic [WIDTH-1:0]   plo_q, plo_d;
  logic [2*WIDTH-1:0] arith_res;
  logic               div_by_zero;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .mdop        (MDOP),
    .a           (A),
    .b           (B),
    .result      (arith_res),
    .div_by_zero (div_by_zero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mask_d  = mask_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    case (state_q)
      MD_IDLE: begin
        if (Start) begin
          case (MDOP)
            MD_MULT, MD_MULTU: begin
              state_d = MD_BUSY;
              busy_d  = 1'b1;
              cnt_d   = CNT_W'(MULT_CYCLES);
              mask_d  = 1'b0;
              phi_d   = arith_res[2*WIDTH-1:WIDTH];
              plo_d   = arith_res[WIDTH-1:0];
            end
            MD_DIV, MD_DIVU: begin
              state_d = MD_BUSY;
              busy_d  = 1'b1;
              cnt_d   = CNT_W'(DIV_CYCLES);
              // A zero divisor still occupies the unit but must not touch HI/LO.
              mask_d  = div_by_zero;
              if (!div_by_zero) begin
                phi_d = arith_res[2*WIDTH-1:WIDTH];
                plo_d = arith_res[WIDTH-1:0];
              end
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = MD_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (!mask_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mask_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mask_q  <= mask_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

  assign Busy  = busy_q;
  assign Done  = done_q;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign Stall = MDUse & (Start | busy_q);

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: driver pushes reference results for
// long ops, a negedge monitor checks each Done commit and the busy window.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  MDOP = 3'b111;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        MDUse = 1'b0;
  logic        Busy, Done, Stall;
  logic [31:0] HI, LO;

  md_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Start (Start),
    .MDOP  (MDOP),
    .A     (A),
    .B     (B),
    .MDUse (MDUse),
    .Busy  (Busy),
    .Done  (Done),
    .Stall (Stall),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        keep;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] arch_hi = '0;
  logic [31:0] arch_lo = '0;
  int          busy_run = 0;
  logic        done_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: MIPS mult/div semantics written with 64-bit integer arithmetic.
  function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint p, q, r;
    logic [63:0] v;
    e.hi = '0; e.lo = '0; e.keep = 1'b0; e.lat = 10;
    case (op)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        v = p; e.hi = v[63:32]; e.lo = v[31:0]; e.lat = 5;
      end
      3'd1: begin
        v = {32'd0, a} * {32'd0, b};
        e.hi = v[63:32]; e.lo = v[31:0]; e.lat = 5;
      end
      3'd2: begin
        if (b == 0) e.keep = 1'b1;
        else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          v = q; e.lo = v[31:0];
          v = r; e.hi = v[31:0];
        end
      end
      default: begin
        if (b == 0) e.keep = 1'b1;
        else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Called at a negedge; presents Start for one clock edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit accept);
    Start = 1'b1; MDOP = op; A = a; B = b;
    if (accept && op < 3'd4) sb_q.push_back(ref_model(op, a, b));
    @(negedge clk);
    Start = 1'b0; MDOP = 3'b111;
    if (accept && (op == 3'd4 || op == 3'd5)) begin
      if (op == 3'd4) arch_hi = a; else arch_lo = a;
      chk("mt_hi", HI, arch_hi);
      chk("mt_lo", LO, arch_lo);
      chk("mt_busy", Busy, 0);
    end else if (accept && op >= 3'd6) begin
      chk("noop_busy", Busy, 0);
      chk("noop_hi", HI, arch_hi);
      chk("noop_lo", LO, arch_lo);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((Busy || Done || sb_q.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL idle_timeout: Busy=%0b queued=%0d", Busy, sb_q.size());
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (Done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL done_timeout: Done=%0b after %0d cycles", Done, n);
    end
  endtask

  // Monitor: every Done pops one expected commit; HI/LO must hold while busy.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_run  = 0;
        done_prev = 1'b0;
      end else begin
        if (Busy) begin
          busy_run++;
          chk("hold_hi", HI, arch_hi);
          chk("hold_lo", LO, arch_lo);
        end
        if (Done) begin
          chk("done_single", done_prev, 0);
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got Done=1 expected no commit");
          end else begin
            e = sb_q.pop_front();
            if (!e.keep) begin
              arch_hi = e.hi;
              arch_lo = e.lo;
            end
            chk("commit_hi", HI, arch_hi);
            chk("commit_lo", LO, arch_lo);
            chk("busy_cycles", busy_run, e.lat);
            chk("busy_low_at_done", Busy, 0);
          end
          busy_run = 0;
        end
        done_prev = Done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;

    @(negedge clk);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    chk("rst_stall", Stall, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Signed multiply plus stall while busy.
    issue(3'd0, 32'hFFFFFFFF, 32'h00000002, 1);
    chk("busy_after_start", Busy, 1);
    MDUse = 1'b1; #1;
    chk("stall_busy_use", Stall, 1);
    MDUse = 1'b0; #1;
    chk("stall_busy_nouse", Stall, 0);
    wait_idle();
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFE);

    issue(3'd1, 32'hFFFFFFFF, 32'h00000002, 1);
    wait_idle();
    chk("multu_hi", HI, 32'h00000001);
    chk("multu_lo", LO, 32'hFFFFFFFE);

    issue(3'd2, 32'hFFFFFFF9, 32'h00000002, 1);
    wait_idle();
    chk("div_hi", HI, 32'hFFFFFFFF);
    chk("div_lo", LO, 32'hFFFFFFFD);

    issue(3'd3, 32'h00000007, 32'h00000000, 1);
    wait_idle();
    chk("divu0_hi", HI, 32'hFFFFFFFF);
    chk("divu0_lo", LO, 32'hFFFFFFFD);

    // MTHI then MTLO on consecutive edges.
    Start = 1'b1; MDOP = 3'd4; A = 32'h12345678;
    @(negedge clk);
    chk("mthi_hi", HI, 32'h12345678);
    chk("mthi_busy", Busy, 0);
    arch_hi = 32'h12345678;
    MDOP = 3'd5; A = 32'h9ABCDEF0;
    @(negedge clk);
    Start = 1'b0; MDOP = 3'b111;
    chk("mtlo_lo", LO, 32'h9ABCDEF0);
    chk("mtlo_hi", HI, 32'h12345678);
    chk("mtlo_busy", Busy, 0);
    arch_lo = 32'h9ABCDEF0;

    // Stall from Start alone, carried by a no-op command.
    Start = 1'b1; MDOP = 3'b110; MDUse = 1'b1; #1;
    chk("stall_start_use", Stall, 1);
    MDUse = 1'b0;
    @(negedge clk);
    Start = 1'b0; MDOP = 3'b111;
    chk("noop_busy", Busy, 0);
    chk("noop_hi", HI, arch_hi);
    chk("noop_lo", LO, arch_lo);

    // A MULT arriving mid-divide must be dropped.
    issue(3'd2, 32'd1000, 32'd7, 1);
    @(negedge clk);
    issue(3'd0, 32'h00010000, 32'h00010000, 0);
    wait_idle();
    chk("ign_hi", HI, 32'd6);
    chk("ign_lo", LO, 32'd142);

    // Back-to-back: next start in the Done cycle.
    issue(3'd1, 32'hDEADBEEF, 32'h01234567, 1);
    wait_done();
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom();
      b  = $urandom();
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 15) == 0) b = 32'($urandom_range(1, 5));
      issue(op, a, b, 1);
      wait_idle();
    end

    // Asynchronous reset in the middle of a divide.
    issue(3'd2, 32'd100, 32'd7, 1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    arch_hi = '0;
    arch_lo = '0;
    #1;
    chk("arst_busy", Busy, 0);
    chk("arst_done", Done, 0);
    chk("arst_hi", HI, 0);
    chk("arst_lo", LO, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    chk("post_rst_hi", HI, 0);
    chk("post_rst_lo", LO, 0);
    chk("post_rst_busy", Busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
